// File: rtl/serializer_pkg.sv
// Shared types and widths for the word serializer.
// State encoding plus word/index widths.
package serializer_pkg;

  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux16to1.sv
// 16:1 single-bit multiplexer.
// Selects one bit of data by sel.
module mux16to1 (
  input  logic [15:0] data,
  input  logic [3:0]  sel,
  output logic        y
);

  assign y = data[sel];

endmodule

// File: rtl/word_serializer.sv
// 16-bit word to serial bitstream with valid/ready on both sides.
// A load may overlap the last-bit transfer for gapless streaming.
module word_serializer
  import serializer_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WORD_W-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [IDX_W-1:0] LAST = '1;

  state_t            state;
  logic [WORD_W-1:0] held;
  logic [IDX_W-1:0]  pos;
  logic              mux_bit;
  logic              load;
  logic              xfer;

  assign ser_valid  = (state == SHIFT);
  assign ser_last   = ser_valid && (pos == LAST);
  assign load_ready = !ser_valid || (ser_last && ser_ready);
  assign bit_idx    = MSB_FIRST ? (LAST - pos) : pos;

  assign load = load_valid && load_ready;
  assign xfer = ser_valid && ser_ready;

  mux16to1 u_mux (
    .data (held),
    .sel  (bit_idx),
    .y    (mux_bit)
  );

  assign ser_out = ser_valid ? mux_bit : IDLE_LEVEL;

  // A load wins over a plain transfer: it is only possible on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      held  <= '0;
      pos   <= '0;
    end else if (load) begin
      state <= SHIFT;
      held  <= load_data;
      pos   <= '0;
    end else if (xfer) begin
      pos <= pos + 1'b1;
      if (pos == LAST) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: LSB-first and MSB-first serializers side by side.
// Directed scenarios plus a randomized scoreboard run.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lv = 1'b0;
  logic [15:0] ld = '0;
  logic        sr = 1'b1;

  logic       lr0, out0, v0, last0;
  logic [3:0] idx0;
  logic       lr1, out1, v1, last1;
  logic [3:0] idx1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  word_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (lv),
    .load_data  (ld),
    .load_ready (lr0),
    .ser_out    (out0),
    .ser_valid  (v0),
    .ser_ready  (sr),
    .ser_last   (last0),
    .bit_idx    (idx0)
  );

  word_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (lv),
    .load_data  (ld),
    .load_ready (lr1),
    .ser_out    (out1),
    .ser_valid  (v1),
    .ser_ready  (sr),
    .ser_last   (last1),
    .bit_idx    (idx1)
  );

  task automatic test_reset();
    #2;
    tests++;
    if ({v0, last0, lr0, out0, idx0, v1, last1, lr1, out1, idx1}
        !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd15}) begin
      fails++;
      $display("FAIL reset got %b/%b/%b/%b/%0d %b/%b/%b/%b/%0d",
               v0, last0, lr0, out0, idx0, v1, last1, lr1, out1, idx1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [15:0] w;
    w = 16'hA5C3;
    @(negedge clk);
    lv = 1'b1; ld = w; sr = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    #1;
    for (int k = 1; k <= 16; k++) begin
      tests++;
      if ({v0, out0, idx0, last0, lr0}
          !== {1'b1, w[k-1], 4'(k-1), 1'(k == 16), 1'(k == 16)}) begin
        fails++;
        $display("FAIL single lsb k=%0d got v%b o%b i%0d l%b r%b exp o%b",
                 k, v0, out0, idx0, last0, lr0, w[k-1]);
      end
      tests++;
      if ({v1, out1, idx1, last1} !== {1'b1, w[16-k], 4'(16-k), 1'(k == 16)}) begin
        fails++;
        $display("FAIL single msb k=%0d got v%b o%b i%0d l%b exp o%b i%0d",
                 k, v1, out1, idx1, last1, w[16-k], 16 - k);
      end
      @(negedge clk);
      #1;
    end
    tests++;
    if ({v0, lr0, out0, v1, out1} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL single idle got v%b r%b o%b v%b o%b exp 0 1 0 0 1",
               v0, lr0, out0, v1, out1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    lv = 1'b1; ld = 16'hFFFF; sr = 1'b1;
    @(negedge clk);
    ld = 16'h0000;
    for (int k = 1; k <= 32; k++) begin
      if (k > 16) lv = 1'b0;
      #1;
      tests++;
      if ({v0, out0, lr0, last0}
          !== {1'b1, 1'(k <= 16), 1'(k % 16 == 0), 1'(k % 16 == 0)}) begin
        fails++;
        $display("FAIL b2b k=%0d got v%b o%b r%b l%b exp o%b r%b",
                 k, v0, out0, lr0, last0, k <= 16, k % 16 == 0);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (v0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b end valid got %b exp 0", v0);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    logic [3:0]  pat;
    int xf, c;
    w = 16'h8001;
    pat = 4'b1001;
    xf = 0; c = 0;
    @(negedge clk);
    lv = 1'b1; ld = w; sr = 1'b0;
    @(negedge clk);
    lv = 1'b0;
    while (xf < 16 && c < 100) begin
      sr = pat[3 - (c % 4)];
      #1;
      tests++;
      if ({v0, idx0, out0, last0, lr0, idx1}
          !== {1'b1, 4'(xf), w[xf], 1'(xf == 15), 1'(xf == 15 && sr), 4'(15 - xf)}) begin
        fails++;
        $display("FAIL bp c=%0d got v%b i%0d o%b l%b r%b i1=%0d exp i%0d o%b",
                 c, v0, idx0, out0, last0, lr0, idx1, xf, w[xf]);
      end
      if (sr) xf++;
      c++;
      @(negedge clk);
    end
    sr = 1'b1;
    #1;
    tests++;
    if ({xf, v0} !== {32'd16, 1'b0}) begin
      fails++;
      $display("FAIL bp end got xf=%0d v%b exp 16 0", xf, v0);
    end
  endtask

  task automatic test_msb_first();
    @(negedge clk);
    lv = 1'b1; ld = 16'h8000; sr = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    #1;
    for (int k = 1; k <= 16; k++) begin
      tests++;
      if ({v1, out1, idx1, last1, out0}
          !== {1'b1, 1'(k == 1), 4'(16 - k), 1'(k == 16), 1'(k == 16)}) begin
        fails++;
        $display("FAIL msb k=%0d got v%b o%b i%0d l%b lsb_o%b",
                 k, v1, out1, idx1, last1, out0);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_ignored_load();
    logic [15:0] w;
    w = 16'h00FF;
    @(negedge clk);
    lv = 1'b1; ld = w; sr = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      lv = (k == 8);
      ld = (k == 8) ? 16'hDEAD : 16'h0000;
      #1;
      tests++;
      if ({v0, out0, idx0, lr0} !== {1'b1, w[k-1], 4'(k - 1), 1'(k == 16)}) begin
        fails++;
        $display("FAIL ignore k=%0d got v%b o%b i%0d r%b exp o%b",
                 k, v0, out0, idx0, lr0, w[k-1]);
      end
      @(negedge clk);
    end
    lv = 1'b0;
    #1;
    tests++;
    if ({v0, lr0} !== {1'b0, 1'b1}) begin
      fails++;
      $display("FAIL ignore end got v%b r%b exp 0 1", v0, lr0);
    end
  endtask

  task automatic test_midword_reset();
    @(negedge clk);
    lv = 1'b1; ld = 16'h1234; sr = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if ({v0, idx0} !== {1'b1, 4'd5}) begin
      fails++;
      $display("FAIL rst pre got v%b i%0d exp 1 5", v0, idx0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({v0, lr0, last0, out0, idx0, v1, lr1, out1, idx1}
        !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd15}) begin
      fails++;
      $display("FAIL rst async got v%b r%b l%b o%b i%0d v%b r%b o%b i%0d",
               v0, lr0, last0, out0, idx0, v1, lr1, out1, idx1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lv = 1'b1; ld = 16'h0001;
    @(negedge clk);
    lv = 1'b0;
    #1;
    for (int k = 1; k <= 16; k++) begin
      tests++;
      if ({v0, out0, idx0} !== {1'b1, 1'(k == 1), 4'(k - 1)}) begin
        fails++;
        $display("FAIL rst after k=%0d got v%b o%b i%0d", k, v0, out0, idx0);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [15:0] g0, g1, e;
    bit busy, rdy;
    int sent, done, c;
    busy = 0; sent = 0; done = 0; c = 0;
    g0 = '0; g1 = '0;
    while (c < 3000 && (c < 1500 || busy)) begin
      @(negedge clk);
      lv = (c < 1500) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      ld = 16'($urandom);
      sr = (c < 1500) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      rdy = !busy || (sent == 15 && sr);
      tests++;
      if ({v0, lr0, v1, lr1} !== {busy, rdy, busy, rdy}) begin
        fails++;
        $display("FAIL rand c=%0d got v%b r%b v%b r%b exp v%b r%b",
                 c, v0, lr0, v1, lr1, busy, rdy);
      end
      if (busy && sr) begin
        g0[sent] = out0;
        g1[15 - sent] = out1;
        sent++;
        if (sent == 16) begin
          e = q.pop_front();
          tests++;
          if ({g0, g1} !== {e, e}) begin
            fails++;
            $display("FAIL rand word got %h/%h exp %h", g0, g1, e);
          end
          done++;
          busy = 0;
          sent = 0;
        end
      end
      if (lv && rdy) begin
        q.push_back(ld);
        busy = 1;
        sent = 0;
      end
      c++;
    end
    tests++;
    if (busy || done < 20) begin
      fails++;
      $display("FAIL rand drain got busy=%0d words=%0d exp 0 >=20", busy, done);
    end
    lv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_msb_first();
    test_ignored_load();
    test_midword_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
